// File: rtl/mic_ram_sched.sv
// Single-port sample RAM scheduler: writes one four-channel microphone frame per frame_stb
// and arbitrates the same port for a handshaked reader. Writes win over reads.
module mic_ram_sched #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WIDTH  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              frame_stb,
  input  logic [WIDTH-1:0]  mic_0,
  input  logic [WIDTH-1:0]  mic_1,
  input  logic [WIDTH-1:0]  mic_2,
  input  logic [WIDTH-1:0]  mic_3,
  output logic              ram_we,
  output logic [ADDR_W+1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  input  logic [WIDTH-1:0]  ram_rdata,
  input  logic              rd_req,
  input  logic [ADDR_W+1:0] rd_addr,
  output logic              rd_ack,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              frame_done,
  output logic              overrun,
  input  logic              clr_overrun
);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRdw, StAck} state_e;

  state_e              state_q, state_d;
  logic [1:0]          ch_q, ch_d;
  logic                pending_q, pending_d, pending_clr;
  logic [WIDTH-1:0]    sh_q [4];
  logic                accept, drop;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W+1:0]   ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0]    ram_wdata_q, ram_wdata_d;
  logic                rd_ack_q, rd_ack_d;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;

  // A frame landing on the edge that registers the last word is accepted, not dropped.
  always_comb begin
    accept    = frame_stb & (~pending_q | pending_clr);
    drop      = frame_stb & pending_q & ~pending_clr;
    pending_d = accept ? 1'b1 : (pending_q & ~pending_clr);
    overrun_d = drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
  end

  // Register values are those seen while in the state being entered.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    pending_clr  = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    rd_ack_d     = 1'b0;
    rd_data_d    = rd_data_q;
    wr_ptr_d     = wr_ptr_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d     = StWr;
          ch_d        = 2'd0;
          ram_we_d    = 1'b1;
          ram_addr_d  = {wr_ptr_q, 2'd0};
          ram_wdata_d = sh_q[0];
        end else if (rd_req) begin
          state_d    = StRd;
          ram_addr_d = rd_addr;
        end
      end
      StWr: begin
        if (ch_q == 2'd3) begin
          state_d      = StIdle;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          frame_done_d = 1'b1;
        end else begin
          ch_d        = ch_q + 2'd1;
          ram_we_d    = 1'b1;
          ram_addr_d  = {wr_ptr_q, ch_d};
          ram_wdata_d = sh_q[ch_d];
          pending_clr = (ch_d == 2'd3);
        end
      end
      StRd:  state_d = StRdw;
      StRdw: begin
        state_d   = StAck;
        rd_ack_d  = 1'b1;
        rd_data_d = ram_rdata;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      ch_q         <= 2'd0;
      pending_q    <= 1'b0;
      for (int i = 0; i < 4; i++) sh_q[i] <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rd_ack_q     <= 1'b0;
      rd_data_q    <= '0;
      wr_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      pending_q    <= pending_d;
      if (accept) begin
        sh_q[0] <= mic_0;
        sh_q[1] <= mic_1;
        sh_q[2] <= mic_2;
        sh_q[3] <= mic_3;
      end
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_ack_q     <= rd_ack_d;
      rd_data_q    <= rd_data_d;
      wr_ptr_q     <= wr_ptr_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign rd_ack     = rd_ack_q;
  assign rd_data    = rd_data_q;
  assign wr_ptr     = wr_ptr_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
